mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (IF) and the load/store unit (LS).
- Accepts one request at a time and holds it in a capture register.
- Issues the request to memory and routes the response back to its owner.
- Drives gnt_sel, the registered owner ID, which is the select for the mux2 instances steering address, write data and response return.

Parameters:
XLEN, 32, data/address width; XLEN/8 byte strobes.
STARVE_LIMIT, 4, number of consecutive contested LS wins after which IF is forced to win; legal range 1..15.

Ports:
clk  in  1  core clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
if_req_valid  in  1  IF read request pending
if_req_addr  in  XLEN  IF read address
if_req_ready  out  1  IF request accepted this cycle
if_resp_valid  out  1  resp_rdata valid for IF
ls_req_valid  in  1  LS request pending
ls_req_addr  in  XLEN  LS address
ls_req_we  in  1  LS write enable
ls_req_wdata  in  XLEN  LS write data
ls_req_wstrb  in  XLEN/8  LS byte strobes
ls_req_ready  out  1  LS request accepted this cycle
ls_resp_valid  out  1  resp_rdata valid for LS
resp_rdata  out  XLEN  shared response data (= mem_rdata)
mem_valid  out  1  request presented to memory
mem_addr  out  XLEN  captured address
mem_we  out  1  captured write enable
mem_wdata  out  XLEN  captured write data
mem_wstrb  out  XLEN/8  captured strobes
mem_ready  in  1  memory accepts request
mem_rvalid  in  1  memory response/ack (reads and writes)
mem_rdata  in  XLEN  memory read data
gnt_sel  out  1  owner of current transaction; 0 = IF, 1 = LS
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT. At most one transaction is outstanding.

IDLE:
- If any req_valid is high, pick a winner combinationally and assert that requester's req_ready for that cycle only.
- Capture addr/we/wdata/wstrb into registers. An IF capture forces we=0 and wstrb=0.
- Load gnt_sel with the winner and move to ISSUE.
- With no request, stay in IDLE; all ready signals stay 0.

Arbitration:
- LS wins by default.
- IF wins if only IF is valid, or if both are valid and starve_cnt == STARVE_LIMIT.
- starve_cnt increments, saturating, on each both-valid cycle that LS wins. It clears to 0 on any IF grant.
- starve_cnt width is 4 bits.

ISSUE:
- mem_valid=1 with the captured fields, held stable until mem_ready.
- On mem_ready, go to WAIT. mem_valid drops in the following cycle.

WAIT:
- mem_valid=0. When mem_rvalid is high, pulse the owner's resp_valid combinationally in the same cycle and return to IDLE.
- The non-owner's resp_valid is always 0.
- resp_rdata is continuous pass-through of mem_rdata and is only meaningful when a resp_valid is high.

Timing and protocol rules:
- Minimum transaction length is 3 cycles: accept, issue with mem_ready=1, then rvalid in the first WAIT cycle.
- A new accept can occur in the cycle after the response.
- mem_rvalid is ignored in IDLE and ISSUE. Memory guarantees rvalid comes at least 1 cycle after mem_ready.
- Requesters hold valid and fields stable until ready. A request must not be withdrawn once valid.

Reset:
- rst_n low gives state=IDLE, starve_cnt=0, gnt_sel=0, captured fields=0, immediately and asynchronously.
- Every output is 0 except resp_rdata, which follows mem_rdata.
- Reset during ISSUE/WAIT drops the transaction: no resp_valid is produced, and a late mem_rvalid seen in IDLE is ignored.

Test Plan:
- Lone IF read, addr 0x100; mem_ready=1 in the ISSUE cycle; mem_rdata=0xDEADBEEF with rvalid 2 cycles later -> if_req_ready pulses at cycle 0; mem_valid=1, mem_addr=0x100, mem_we=0 at cycle 1; if_resp_valid=1 with resp_rdata=0xDEADBEEF; gnt_sel=0; ls_resp_valid never set.
- IF and LS both valid from IDLE -> LS accepted first (gnt_sel=1); IF accepted in the IDLE cycle after LS's response.
- Both continuously valid, STARVE_LIMIT=4 -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF; starve_cnt returns to 0 after each IF grant.
- LS write addr 0x2000, wdata 0xA5A5_1234, wstrb 4'b0011; mem_ready held low for 3 ISSUE cycles -> mem_valid and all mem_* fields stable for 4 cycles; mem_we=1; ls_resp_valid pulses on mem_rvalid.
- rst_n driven low in WAIT -> busy, mem_valid and all ready/resp_valid outputs go 0 asynchronously; after release, mem_rvalid=1 in IDLE produces no resp_valid.
- mem_rvalid=1 asserted spuriously during ISSUE -> ignored; the response is delivered only on the rvalid that arrives in WAIT.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between instruction fetch
// (IF) and the load/store unit (LS). One transaction in flight at a time:
// accept into capture registers, issue to memory, route the response to the
// owner. o_gnt_sel is the registered owner (0 = IF, 1 = LS) and steers the
// external address/write-data/response muxes.
module mem_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,

    // Instruction-fetch requester (read only)
    input  logic                i_if_req_valid,
    input  logic [XLEN-1:0]     i_if_req_addr,
    output logic                o_if_req_ready,
    output logic                o_if_resp_valid,

    // Load/store requester
    input  logic                i_ls_req_valid,
    input  logic [XLEN-1:0]     i_ls_req_addr,
    input  logic                i_ls_req_we,
    input  logic [XLEN-1:0]     i_ls_req_wdata,
    input  logic [XLEN/8-1:0]   i_ls_req_wstrb,
    output logic                o_ls_req_ready,
    output logic                o_ls_resp_valid,

    // Shared response data
    output logic [XLEN-1:0]     o_resp_rdata,

    // Memory side
    output logic                o_mem_valid,
    output logic [XLEN-1:0]     o_mem_addr,
    output logic                o_mem_we,
    output logic [XLEN-1:0]     o_mem_wdata,
    output logic [XLEN/8-1:0]   o_mem_wstrb,
    input  logic                i_mem_ready,
    input  logic                i_mem_rvalid,
    input  logic [XLEN-1:0]     i_mem_rdata,

    // Status
    output logic                o_gnt_sel,
    output logic                o_busy
);

    localparam int unsigned    StrbW     = XLEN / 8;
    localparam logic [3:0]     StarveLim = 4'(STARVE_LIMIT);
    localparam logic [3:0]     StarveSat = 4'hF;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_next;

    logic [3:0]         r_starve_cnt;
    logic               r_gnt_sel;
    logic [XLEN-1:0]    r_addr;
    logic               r_we;
    logic [XLEN-1:0]    r_wdata;
    logic [StrbW-1:0]   r_wstrb;

    logic               w_idle_live;
    logic               w_if_wins;
    logic               w_accept;
    logic [XLEN-1:0]    w_cap_addr;
    logic               w_cap_we;
    logic [XLEN-1:0]    w_cap_wdata;
    logic [StrbW-1:0]   w_cap_wstrb;

    // Arbitration: LS by default, IF when alone or when LS has starved it.
    always_comb begin
        w_idle_live = (r_state == StIdle) && i_rst_n;
        w_if_wins   = i_if_req_valid &&
                      (!i_ls_req_valid || (r_starve_cnt == StarveLim));
        w_accept    = w_idle_live && (i_if_req_valid || i_ls_req_valid);
    end

    // Capture mux: an IF winner is always a read with no strobes.
    always_comb begin
        w_cap_addr  = i_ls_req_addr;
        w_cap_we    = i_ls_req_we;
        w_cap_wdata = i_ls_req_wdata;
        w_cap_wstrb = i_ls_req_wstrb;
        if (w_if_wins) begin
            w_cap_addr  = i_if_req_addr;
            w_cap_we    = 1'b0;
            w_cap_wdata = '0;
            w_cap_wstrb = '0;
        end
    end

    // Next-state logic and requester/memory handshake outputs.
    always_comb begin
        w_state_next    = r_state;
        o_if_req_ready  = 1'b0;
        o_ls_req_ready  = 1'b0;
        o_if_resp_valid = 1'b0;
        o_ls_resp_valid = 1'b0;
        o_mem_valid     = 1'b0;
        case (r_state)
            StIdle: begin
                // Ready is gated by reset so nothing is accepted while held.
                o_if_req_ready = w_idle_live && w_if_wins;
                o_ls_req_ready = w_idle_live && i_ls_req_valid && !w_if_wins;
                if (w_accept) begin
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                // Any rvalid here is spurious and deliberately ignored.
                o_mem_valid = 1'b1;
                if (i_mem_ready) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (i_mem_rvalid) begin
                    o_if_resp_valid = !r_gnt_sel;
                    o_ls_resp_valid = r_gnt_sel;
                    w_state_next    = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Starvation counter: counts contested LS wins, cleared by any IF grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (w_accept) begin
            if (w_if_wins) begin
                r_starve_cnt <= 4'd0;
            end else if (i_if_req_valid && (r_starve_cnt != StarveSat)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    // Capture registers and owner, loaded only on an accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt_sel <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_accept) begin
            r_gnt_sel <= !w_if_wins;
            r_addr    <= w_cap_addr;
            r_we      <= w_cap_we;
            r_wdata   <= w_cap_wdata;
            r_wstrb   <= w_cap_wstrb;
        end
    end

    // Registered fields drive memory directly so they stay stable in ISSUE.
    always_comb begin
        o_mem_addr   = r_addr;
        o_mem_we     = r_we;
        o_mem_wdata  = r_wdata;
        o_mem_wstrb  = r_wstrb;
        o_gnt_sel    = r_gnt_sel;
        o_busy       = (r_state != StIdle);
        o_resp_rdata = i_mem_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs are driven 1 time unit after the
// rising edge and outputs are checked 2 units later, well away from edges.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic        ls_req_valid;
    logic [31:0] ls_req_addr;
    logic        ls_req_we;
    logic [31:0] ls_req_wdata;
    logic [3:0]  ls_req_wstrb;
    logic        ls_req_ready;
    logic        ls_resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        gnt_sel;
    logic        busy;

    int n_cmp;
    int n_err;

    mem_port_arbiter #(
        .XLEN         (32),
        .STARVE_LIMIT (4)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_if_req_valid  (if_req_valid),
        .i_if_req_addr   (if_req_addr),
        .o_if_req_ready  (if_req_ready),
        .o_if_resp_valid (if_resp_valid),
        .i_ls_req_valid  (ls_req_valid),
        .i_ls_req_addr   (ls_req_addr),
        .i_ls_req_we     (ls_req_we),
        .i_ls_req_wdata  (ls_req_wdata),
        .i_ls_req_wstrb  (ls_req_wstrb),
        .o_ls_req_ready  (ls_req_ready),
        .o_ls_resp_valid (ls_resp_valid),
        .o_resp_rdata    (resp_rdata),
        .o_mem_valid     (mem_valid),
        .o_mem_addr      (mem_addr),
        .o_mem_we        (mem_we),
        .o_mem_wdata     (mem_wdata),
        .o_mem_wstrb     (mem_wstrb),
        .i_mem_ready     (mem_ready),
        .i_mem_rvalid    (mem_rvalid),
        .i_mem_rdata     (mem_rdata),
        .o_gnt_sel       (gnt_sel),
        .o_busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0000_0F00;
        ls_req_valid = 1'b0;
        ls_req_addr  = 32'h0;
        ls_req_we    = 1'b0;
        ls_req_wdata = 32'h0;
        ls_req_wstrb = 4'h0;
        mem_ready    = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = 32'h5A5A_5A5A;

        // Reset: all outputs 0 even with IF valid, rdata passes through.
        #2;
        chk("rst_if_ready", if_req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_gnt_sel", gnt_sel, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rdata", resp_rdata, 32'h5A5A_5A5A);
        if_req_valid = 1'b0;
        #1 rst_n = 1'b1;
        step();

        // Lone IF read at 0x100, ready in first ISSUE cycle, rvalid 2 later.
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0000_0100;
        #2;
        chk("t1_if_ready", if_req_ready, 1);
        chk("t1_ls_ready", ls_req_ready, 0);
        step();
        if_req_valid = 1'b0;
        mem_ready    = 1'b1;
        #2;
        chk("t1_if_ready_issue", if_req_ready, 0);
        chk("t1_mem_valid", mem_valid, 1);
        chk("t1_mem_addr", mem_addr, 32'h0000_0100);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_wstrb", mem_wstrb, 0);
        chk("t1_gnt_sel", gnt_sel, 0);
        step();
        mem_ready = 1'b0;
        #2;
        chk("t1_wait_mem_valid", mem_valid, 0);
        chk("t1_wait_if_resp", if_resp_valid, 0);
        chk("t1_wait_busy", busy, 1);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        #2;
        chk("t1_if_resp", if_resp_valid, 1);
        chk("t1_ls_resp", ls_resp_valid, 0);
        chk("t1_rdata", resp_rdata, 32'hDEAD_BEEF);
        step();
        mem_rvalid = 1'b0;
        #2;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_if_resp", if_resp_valid, 0);

        // Both valid from IDLE: LS first, IF right after LS's response.
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0000_0200;
        ls_req_valid = 1'b1;
        ls_req_addr  = 32'h0000_3000;
        ls_req_we    = 1'b0;
        #1;
        chk("t2_ls_ready", ls_req_ready, 1);
        chk("t2_if_ready", if_req_ready, 0);
        step();
        ls_req_valid = 1'b0;
        mem_ready    = 1'b1;
        #2;
        chk("t2_gnt_sel_ls", gnt_sel, 1);
        chk("t2_mem_addr_ls", mem_addr, 32'h0000_3000);
        chk("t2_if_ready_issue", if_req_ready, 0);
        step();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        #2;
        chk("t2_ls_resp", ls_resp_valid, 1);
        chk("t2_if_resp", if_resp_valid, 0);
        chk("t2_if_ready_wait", if_req_ready, 0);
        step();
        mem_rvalid = 1'b0;
        #2;
        chk("t2_if_ready_after", if_req_ready, 1);
        step();
        if_req_valid = 1'b0;
        mem_ready    = 1'b1;
        #2;
        chk("t2_gnt_sel_if", gnt_sel, 0);
        chk("t2_mem_addr_if", mem_addr, 32'h0000_0200);
        step();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        #2;
        chk("t2_if_resp_2", if_resp_valid, 1);
        step();
        mem_rvalid = 1'b0;

        // Starvation: both held valid, LIMIT=4 -> LS x4, IF, LS x4, IF.
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        ls_req_addr  = 32'h0000_4000;
        for (int i = 0; i < 10; i++) begin
            #2;
            chk($sformatf("t3_ls_ready_%0d", i), ls_req_ready, (i != 4 && i != 9) ? 1 : 0);
            chk($sformatf("t3_if_ready_%0d", i), if_req_ready, (i == 4 || i == 9) ? 1 : 0);
            step();
            mem_ready = 1'b1;
            #2;
            chk($sformatf("t3_gnt_sel_%0d", i), gnt_sel, (i != 4 && i != 9) ? 1 : 0);
            step();
            mem_ready  = 1'b0;
            mem_rvalid = 1'b1;
            #2;
            chk($sformatf("t3_ls_resp_%0d", i), ls_resp_valid, (i != 4 && i != 9) ? 1 : 0);
            step();
            mem_rvalid = 1'b0;
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;

        // LS write held in ISSUE by 3 cycles of mem_ready low.
        ls_req_valid = 1'b1;
        ls_req_addr  = 32'h0000_2000;
        ls_req_we    = 1'b1;
        ls_req_wdata = 32'hA5A5_1234;
        ls_req_wstrb = 4'b0011;
        #2;
        chk("t4_ls_ready", ls_req_ready, 1);
        step();
        ls_req_valid = 1'b0;
        ls_req_addr  = 32'hFFFF_FFFF;
        ls_req_we    = 1'b0;
        ls_req_wdata = 32'h0;
        ls_req_wstrb = 4'h0;
        for (int c = 0; c < 4; c++) begin
            mem_ready = (c == 3);
            #2;
            chk($sformatf("t4_mem_valid_%0d", c), mem_valid, 1);
            chk($sformatf("t4_mem_addr_%0d", c), mem_addr, 32'h0000_2000);
            chk($sformatf("t4_mem_we_%0d", c), mem_we, 1);
            chk($sformatf("t4_mem_wdata_%0d", c), mem_wdata, 32'hA5A5_1234);
            chk($sformatf("t4_mem_wstrb_%0d", c), mem_wstrb, 4'b0011);
            step();
        end
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        #2;
        chk("t4_mem_valid_wait", mem_valid, 0);
        chk("t4_ls_resp", ls_resp_valid, 1);
        chk("t4_if_resp", if_resp_valid, 0);
        step();
        mem_rvalid = 1'b0;

        // Reset asserted in WAIT drops the transaction asynchronously.
        ls_req_valid = 1'b1;
        ls_req_addr  = 32'h0000_5000;
        ls_req_we    = 1'b0;
        step();
        ls_req_valid = 1'b0;
        mem_ready    = 1'b1;
        step();
        mem_ready    = 1'b0;
        if_req_valid = 1'b1;
        #2;
        chk("t5_busy_wait", busy, 1);
        mem_rvalid = 1'b1;
        rst_n      = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_mem_valid", mem_valid, 0);
        chk("t5_rst_ls_resp", ls_resp_valid, 0);
        chk("t5_rst_if_resp", if_resp_valid, 0);
        chk("t5_rst_if_ready", if_req_ready, 0);
        chk("t5_rst_gnt_sel", gnt_sel, 0);
        chk("t5_rst_mem_addr", mem_addr, 0);
        if_req_valid = 1'b0;
        #1 rst_n = 1'b1;
        step();
        #2;
        chk("t5_late_ls_resp", ls_resp_valid, 0);
        chk("t5_late_if_resp", if_resp_valid, 0);
        chk("t5_late_busy", busy, 0);
        step();
        mem_rvalid = 1'b0;

        // Spurious rvalid during ISSUE is ignored.
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0000_0044;
        step();
        if_req_valid = 1'b0;
        mem_rvalid   = 1'b1;
        #2;
        chk("t6_issue_if_resp_a", if_resp_valid, 0);
        chk("t6_issue_busy", busy, 1);
        step();
        mem_ready = 1'b1;
        #2;
        chk("t6_issue_if_resp_b", if_resp_valid, 0);
        chk("t6_issue_mem_valid", mem_valid, 1);
        step();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        #2;
        chk("t6_wait_if_resp", if_resp_valid, 0);
        chk("t6_wait_busy", busy, 1);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_0044;
        #2;
        chk("t6_if_resp", if_resp_valid, 1);
        chk("t6_rdata", resp_rdata, 32'hCAFE_0044);
        step();
        mem_rvalid = 1'b0;
        #2;
        chk("t6_end_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
